alu_share_arbiter: RTL and testbench

//  Shares one alu instance between two requesters (port 0: main execute path, port 1: branch/aux unit).

---
 rtl/alu_share_arbiter_pkg.sv | 34 +++
 rtl/alu_share_arbiter_alu.sv | 61 ++++++
 rtl/alu_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter_pkg
//  Description : Shared definitions for the alu sharing arbiter: alu_ctrl
//                operation codes and the arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_share_arbiter_pkg;

    // alu_ctrl operation codes (bit 3 selects the SUB/SRA variant)
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;

    // Arbiter FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_EXEC = c_ST_EXEC,
        ST_RESP = c_ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational integer alu.
//                Ports: a, b (WIDTH operands), alu_ctrl (4-bit op code),
//                alu_out (WIDTH result), zero (alu_out == 0),
//                carryout (carry of ADD / no-borrow of SUB, else 0).
//                Unknown op codes return all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carryout
);
    import alu_share_arbiter_pkg::*;

    localparam int c_SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [c_SHW-1:0] w_shamt;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    // a - b as a + ~b + 1, so the top bit is the "no borrow" carry
    assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = b[c_SHW-1:0];

    always_comb begin
        alu_out  = '1;
        carryout = 1'b0;
        case (alu_ctrl)
            c_ALU_ADD: begin
                alu_out  = w_sum[WIDTH-1:0];
                carryout = w_sum[WIDTH];
            end
            c_ALU_SUB: begin
                alu_out  = w_diff[WIDTH-1:0];
                carryout = w_diff[WIDTH];
            end
            c_ALU_SLL:  alu_out = a << w_shamt;
            c_ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            c_ALU_XOR:  alu_out = a ^ b;
            c_ALU_SRL:  alu_out = a >> w_shamt;
            c_ALU_SRA:  alu_out = WIDTH'($signed(a) >>> w_shamt);
            c_ALU_OR:   alu_out = a | b;
            c_ALU_AND:  alu_out = a & b;
            default:    alu_out = '1;
        endcase
    end

    assign zero = (alu_out == '0);

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one alu between two requesters. One operation at a
//                time is accepted (round-robin on ties), evaluated on the alu
//                for one cycle, and its registered result held until the
//                owning port accepts it.
//                Ports: clk, reset (sync, active-high);
//                  req{0,1}_valid/_ready/_a/_b/_ctrl : operation requests
//                  rsp{0,1}_valid/_ready             : per-port result handshake
//                  rsp_result/rsp_zero/rsp_carryout  : shared registered result
//                  busy                              : FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carryout,
    output logic             busy
);
    import alu_share_arbiter_pkg::*;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [3:0]       r_op_ctrl;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_carry;

    logic             w_grant_port;
    logic             w_accept;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_owner_rsp_ready;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zero;
    logic             w_alu_carry;

    // A lone requester wins outright; on a tie the port that did not win
    // last time is granted.
    always_comb begin
        w_grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_port = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_port = 1'b1;
        end
    end

    assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_grant_port;
                    w_req1_ready = w_grant_port;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (w_owner_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op_a       <= w_grant_port ? req1_a    : req0_a;
                r_op_b       <= w_grant_port ? req1_b    : req0_b;
                r_op_ctrl    <= w_grant_port ? req1_ctrl : req0_ctrl;
                r_owner      <= w_grant_port;
                r_last_grant <= w_grant_port;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_result <= w_alu_out;
                r_rsp_zero   <= w_alu_zero;
                r_rsp_carry  <= w_alu_carry;
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a        (r_op_a),
        .b        (r_op_b),
        .alu_ctrl (r_op_ctrl),
        .alu_out  (w_alu_out),
        .zero     (w_alu_zero),
        .carryout (w_alu_carry)
    );

    // Every output is forced low while reset is asserted, including the
    // cycle in which reset arrives mid-operation.
    assign req0_ready   = w_req0_ready & ~reset;
    assign req1_ready   = w_req1_ready & ~reset;
    assign rsp0_valid   = (r_state == ST_RESP) & ~r_owner & ~reset;
    assign rsp1_valid   = (r_state == ST_RESP) &  r_owner & ~reset;
    assign rsp_result   = reset ? '0 : r_rsp_result;
    assign rsp_zero     = r_rsp_zero  & ~reset;
    assign rsp_carryout = r_rsp_carry & ~reset;
    assign busy         = (r_state != ST_IDLE) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. A transaction
//                model tracks the single outstanding operation, its owner,
//                its age and its expected result, and predicts every output
//                each cycle. Directed scenarios are followed by random
//                traffic with occasional resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]       req0_ctrl = '0, req1_ctrl = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_carryout, busy;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carryout(rsp_carryout),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction model state
    bit               m_pend  = 1'b0;
    int               m_age   = 0;
    bit               m_owner = 1'b0;
    bit               m_prev  = 1'b1;
    logic [WIDTH-1:0] m_res;
    logic             m_zero, m_carry;
    int               n_done  = 0;
    bit               grant_log[$];
    logic [WIDTH-1:0] l_res;
    logic             l_zero, l_carry;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference result: {carryout, zero, result}
    function automatic logic [WIDTH+1:0] alu_ref(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint unsigned  s;
        logic [WIDTH-1:0] r;
        logic             c;
        int               sh;
        sh = int'(b % WIDTH);
        c  = 1'b0;
        case (op)
            4'b0000: begin s = longint'(a) + longint'(b); r = a + b; c = (s >= 64'h1_0000_0000); end
            4'b1000: begin r = a - b; c = (a >= b); end
            4'b0001: r = a << sh;
            4'b0010: r = (int'(a) < int'(b)) ? 1 : 0;
            4'b0011: r = (a < b) ? 1 : 0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = $signed(a) >>> sh;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = {WIDTH{1'b1}};
        endcase
        return {c, (r == 0), r};
    endfunction

    // Called just after the negedge on which inputs were set: checks all
    // outputs against the model, then advances the model across the next edge.
    task automatic step();
        bit win_valid, win, own_ready;
        #1;
        win_valid = 1'b0;
        win       = 1'b0;
        if (reset) begin
            chk_val("rst_req0_ready", req0_ready, 0);
            chk_val("rst_req1_ready", req1_ready, 0);
            chk_val("rst_rsp0_valid", rsp0_valid, 0);
            chk_val("rst_rsp1_valid", rsp1_valid, 0);
            chk_val("rst_result", rsp_result, 0);
            chk_val("rst_zero", rsp_zero, 0);
            chk_val("rst_carry", rsp_carryout, 0);
            chk_val("rst_busy", busy, 0);
            m_pend = 1'b0;
            m_prev = 1'b1;
        end else begin
            if (!m_pend) begin
                if (req0_valid && req1_valid) begin win = !m_prev; win_valid = 1'b1; end
                else if (req0_valid)          begin win = 1'b0;    win_valid = 1'b1; end
                else if (req1_valid)          begin win = 1'b1;    win_valid = 1'b1; end
            end
            chk_val("req0_ready", req0_ready, win_valid && !win);
            chk_val("req1_ready", req1_ready, win_valid && win);
            chk_val("busy", busy, m_pend);
            chk_val("rsp0_valid", rsp0_valid, m_pend && m_age >= 2 && !m_owner);
            chk_val("rsp1_valid", rsp1_valid, m_pend && m_age >= 2 && m_owner);
            if (m_pend && m_age >= 2) begin
                chk_val("rsp_result", rsp_result, m_res);
                chk_val("rsp_zero", rsp_zero, m_zero);
                chk_val("rsp_carry", rsp_carryout, m_carry);
            end
            own_ready = m_owner ? rsp1_ready : rsp0_ready;
            if (m_pend && m_age >= 2 && own_ready) begin
                l_res   = rsp_result;
                l_zero  = rsp_zero;
                l_carry = rsp_carryout;
                n_done++;
                m_pend  = 1'b0;
            end else if (m_pend) begin
                m_age++;
            end else if (win_valid) begin
                m_pend  = 1'b1;
                m_age   = 1;
                m_owner = win;
                m_prev  = win;
                {m_carry, m_zero, m_res} = win ? alu_ref(req1_ctrl, req1_a, req1_b)
                                               : alu_ref(req0_ctrl, req0_a, req0_b);
                grant_log.push_back(win);
            end
        end
    endtask

    task automatic drive_req(input bit port, input logic [3:0] ctrl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (port) begin
            req1_valid = 1'b1; req1_ctrl = ctrl; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_ctrl = ctrl; req0_a = a; req0_b = b;
        end
    endtask

    task automatic noise_reqs();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'($urandom_range(0, 15));
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'($urandom_range(0, 15));
    endtask

    // Runs the in-flight op to its response handshake; the owner holds off
    // rsp_ready for 'hold' RESP cycles while the request side is scrambled.
    task automatic wait_done(input int n0, input int budget, input int hold);
        for (int i = 0; i < budget && n_done == n0; i++) begin
            @(negedge clk);
            noise_reqs();
            rsp0_ready = (i >= 1 + hold);
            rsp1_ready = (i >= 1 + hold);
            step();
        end
        chk_val("rsp_handshake_seen", 64'(n_done != n0), 1);
    endtask

    task automatic run_op(input bit port, input logic [3:0] ctrl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        int n0;
        n0 = n_done;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drive_req(port, ctrl, a, b);
        step();
        chk_val("op_accept", port ? req1_ready : req0_ready, 1);
        wait_done(n0, hold + 10, hold);
    endtask

    initial begin
        int n0;
        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            step();
        end
        @(negedge clk); reset = 1'b0; step();

        // 1: port0 ADD 5+7
        run_op(1'b0, 4'b0000, 32'd5, 32'd7, 0);
        chk_val("t1_result", l_res, 12);
        chk_val("t1_zero", l_zero, 0);
        chk_val("t1_carry", l_carry, 0);

        // 2: port1 SUB
        run_op(1'b1, 4'b1000, 32'd3, 32'd5, 0);
        chk_val("t2_result", l_res, 32'hFFFF_FFFE);
        chk_val("t2_carry", l_carry, 0);
        run_op(1'b1, 4'b1000, 32'd9, 32'd9, 0);
        chk_val("t2b_result", l_res, 0);
        chk_val("t2b_zero", l_zero, 1);
        chk_val("t2b_carry", l_carry, 1);

        // 3: both valid continuously from reset, four ops
        @(negedge clk); reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; step();
        @(negedge clk); reset = 1'b0; step();
        grant_log.delete();
        n0 = n_done;
        for (int i = 0; i < 40 && n_done < n0 + 4; i++) begin
            @(negedge clk);
            drive_req(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            drive_req(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            step();
        end
        chk_val("t3_ops_done", 64'(n_done - n0), 4);
        if (grant_log.size() >= 4) begin
            chk_val("t3_grant0", grant_log[0], 0);
            chk_val("t3_grant1", grant_log[1], 1);
            chk_val("t3_grant2", grant_log[2], 0);
            chk_val("t3_grant3", grant_log[3], 1);
        end else begin
            chk_val("t3_grant_count", grant_log.size(), 4);
        end

        // 4: backpressure on SLL
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0; step();
        run_op(1'b0, 4'b0001, 32'd1, 32'h21, 5);
        chk_val("t4_result", l_res, 2);

        // 5: reset during EXEC of port1 ADD 1+1
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        drive_req(1'b1, 4'b0000, 32'd1, 32'd1);
        step();
        chk_val("t5_accept", req1_ready, 1);
        @(negedge clk); req1_valid = 1'b0; reset = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reset = 1'b0; step();
        end
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        drive_req(1'b0, 4'b0000, 32'd2, 32'd3);
        drive_req(1'b1, 4'b0000, 32'd7, 32'd7);
        step();
        chk_val("t5_tie_req0", req0_ready, 1);
        chk_val("t5_tie_req1", req1_ready, 0);
        wait_done(n_done, 10, 0);
        chk_val("t5_result", l_res, 5);

        // 6: ADD overflow and unknown ctrl
        run_op(1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 0);
        chk_val("t6_result", l_res, 0);
        chk_val("t6_zero", l_zero, 1);
        chk_val("t6_carry", l_carry, 1);
        run_op(1'b1, 4'b1111, $urandom, $urandom, 0);
        chk_val("t6b_result", l_res, 32'hFFFF_FFFF);
        chk_val("t6b_zero", l_zero, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            noise_reqs();
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 49) == 0);
            step();
        end
        @(negedge clk); reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
